nonce_sweeper: RTL

- Initiator side of the header-hash interface: builds 640-bit block headers from a template, issues them to the double-SHA-256 hash core, and collects the digests.
- Sweeps a nonce range and compares each returned digest against a 256-bit target.
- Reports the first nonce that meets the target, or completion or abort.
- Sits between the host control registers and the hash core.

---
 rtl/nonce_sweeper_pkg.sv | 29 ++
 rtl/nonce_sweeper_if.sv | 22 ++
 rtl/nonce_sweeper_digest_cmp.sv | 21 ++
 rtl/nonce_sweeper.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/nonce_sweeper_pkg.sv
// nonce_sweeper shared types, widths and byte-order helpers.
// Optional feature macro: NONCE_SWEEP_TIMEOUT_EN.
package nonce_sweep_pkg;

   localparam int HDR_W     = 640;
   localparam int DIG_W     = 256;
   localparam int NONCE_OFS = 0;
   localparam int NONCE_W   = 32;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      CHECK,
      FIN
   } state_t;

   function automatic logic [31:0] bswap32(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   function automatic logic [255:0] brev256(input logic [255:0] x);
      logic [255:0] r;
      for (int i = 0; i < 32; i++)
         r[8*i +: 8] = x[8*(31-i) +: 8];
      return r;
   endfunction

endpackage

// File: rtl/nonce_sweeper_if.sv
// Header request / digest return channel between sweeper and hash core.
// Optional feature macro: NONCE_SWEEP_TIMEOUT_EN (no effect here).
interface nonce_sweeper_if;
   import nonce_sweep_pkg::*;

   logic             hdr_valid;
   logic             hdr_ready;
   logic [HDR_W-1:0] hdr_out;
   logic             dig_valid;
   logic [DIG_W-1:0] digest;

   modport master (
      output hdr_valid, hdr_out,
      input  hdr_ready, dig_valid, digest
   );

   modport slave (
      input  hdr_valid, hdr_out,
      output hdr_ready, dig_valid, digest
   );

endinterface

// File: rtl/nonce_sweeper_digest_cmp.sv
// Registered digest qualify: byte-reverse then unsigned <= target.
// Optional feature macro: NONCE_SWEEP_TIMEOUT_EN (no effect here).
module digest_cmp
   import nonce_sweep_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [DIG_W-1:0] digest,
   input  logic [DIG_W-1:0] target,
   output logic             qual
);

   always_ff @(posedge clk) begin
      if (!rst_n)
         qual <= 1'b0;
      else if (en)
         qual <= (brev256(digest) <= target);
   end

endmodule

// File: rtl/nonce_sweeper.sv
// Nonce sweep initiator: issues headers, qualifies digests, reports result.
// Optional feature macro: NONCE_SWEEP_TIMEOUT_EN (bounded digest wait).
module nonce_sweeper
  import nonce_sweep_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [HDR_W-1:0] hdr_template,
  input  logic [31:0]      nonce_first,
  input  logic [31:0]      nonce_last,
  input  logic [DIG_W-1:0] target,
  nonce_sweeper_if.master  hif,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [31:0]      found_nonce,
  output logic [32:0]      tried,
  output logic             timeout
);

  localparam logic [32:0] TRIED_MAX = 33'h1_0000_0000;

  state_t                 state;
  logic [HDR_W-1:NONCE_W] tmpl_q;
  logic [31:0]            last_q;
  logic [DIG_W-1:0]       tgt_q;
  logic [32:0]            cnt;
  logic                   abort_q;
  logic                   qual;
  logic                   dig_hit;
  logic                   wait_exp;
  logic                   unused_nonce;

  assign unused_nonce = ^hdr_template[NONCE_OFS +: NONCE_W];
  assign dig_hit      = (state == WAIT) && hif.dig_valid;

  function automatic logic [HDR_W-1:0] mk_hdr(
    input logic [HDR_W-1:NONCE_W] t,
    input logic [31:0]            n
  );
    return {t, bswap32(n)};
  endfunction

  digest_cmp u_cmp (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (dig_hit),
    .digest (hif.digest),
    .target (tgt_q),
    .qual   (qual)
  );

`ifdef NONCE_SWEEP_TIMEOUT_EN
  localparam int WC_W = $clog2(TIMEOUT_CYC + 1);
  logic [WC_W-1:0] wcnt;

  assign wait_exp = (state == WAIT) &&
                    (wcnt == WC_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt    <= '0;
      timeout <= 1'b0;
    end else begin
      wcnt <= (state == WAIT) ? wcnt + 1'b1 : '0;
      if (state == IDLE && start)
        timeout <= 1'b0;
      else if (wait_exp && !hif.dig_valid)
        timeout <= 1'b1;
    end
  end
`else
  assign wait_exp = 1'b0;
  assign timeout  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      hif.hdr_valid <= 1'b0;
      hif.hdr_out   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      found         <= 1'b0;
      found_nonce   <= '0;
      tried         <= '0;
      tmpl_q        <= '0;
      last_q        <= '0;
      tgt_q         <= '0;
      cnt           <= '0;
      abort_q       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          tmpl_q  <= hdr_template[HDR_W-1:NONCE_W];
          last_q  <= nonce_last;
          tgt_q   <= target;
          cnt     <= {1'b0, nonce_first};
          found   <= 1'b0;
          tried   <= '0;
          abort_q <= 1'b0;
          busy    <= 1'b1;
          if (nonce_first > nonce_last) begin
            state <= FIN;
          end else begin
            hif.hdr_out   <= mk_hdr(
              hdr_template[HDR_W-1:NONCE_W],
              nonce_first);
            hif.hdr_valid <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: if (hif.hdr_ready) begin
          hif.hdr_valid <= 1'b0;
          state         <= WAIT;
        end else if (abort) begin
          hif.hdr_valid <= 1'b0;
          state         <= FIN;
        end
        WAIT: begin
          if (abort)
            abort_q <= 1'b1;
          if (hif.dig_valid)
            state <= (abort || abort_q) ? FIN : CHECK;
          else if (wait_exp)
            state <= FIN;
        end
        CHECK: begin
          if (tried != TRIED_MAX)
            tried <= tried + 33'd1;
          if (abort) begin
            state <= FIN;
          end else if (qual) begin
            found       <= 1'b1;
            found_nonce <= cnt[31:0];
            state       <= FIN;
          end else if (cnt >= {1'b0, last_q}) begin
            state <= FIN;
          end else begin
            cnt           <= cnt + 33'd1;
            hif.hdr_out   <= mk_hdr(tmpl_q,
                                    cnt[31:0] + 32'd1);
            hif.hdr_valid <= 1'b1;
            state         <= ISSUE;
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
